// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter
// CPU-side initiator for the banked burst memory interface. Takes whole 256-bit
// cacheline requests from the cache arbiter, splits writes into four 64-bit
// beats and reassembles returning read beats (tagged by raddr) into lines.
// Several line reads may be in flight and may complete in any order.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   dfp_addr/read/write/wdata   line request from the arbiter
//   dfp_ready         request accepted this cycle (with read or write)
//   dfp_resp          one-cycle pulse, dfp_rdata/dfp_raddr hold the completed line
//   dfp_wdone         one-cycle pulse after the last write beat is issued
//   bmem_addr/read/write/wdata  burst request to the memory
//   bmem_ready        memory can accept a new request
//   bmem_raddr/rdata/rvalid     returning read beats
//   err               sticky protocol-error flag
module bmem_line_adapter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BEATS           = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic         dfp_ready,
  output logic         dfp_resp,
  output logic [31:0]  dfp_raddr,
  output logic [255:0] dfp_rdata,
  output logic         dfp_wdone,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid,
  output logic         err
);

  localparam int unsigned IdxW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  // Issue side
  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [255:0]   wline_q;
  logic [26:0]    waddr_q;
  logic           wdone_q, wdone_d;
  logic           rd_accept, wr_accept, req_conflict;

  // Outstanding-read tracker
  logic [MAX_OUTSTANDING-1:0]       valid_q, valid_d;
  logic [MAX_OUTSTANDING-1:0][26:0] taddr_q;
  logic [3:0]                       count_q, count_d;
  logic [IdxW-1:0]                  alloc_idx, hit_idx;
  logic                             hit;

  // Response collection
  logic [1:0]     coll_q, coll_d;
  logic [31:0]    cur_addr_q, cur_addr_d;
  logic [IdxW-1:0] cur_slot_q, cur_slot_d;
  logic [191:0]   rbuf_q, rbuf_d;
  logic           resp_q, resp_d;
  logic [255:0]   rdata_q, rdata_d;
  logic [31:0]    raddr_q, raddr_d;
  logic           err_q, err_d;
  logic           free;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^dfp_addr[4:0];

  // Issue FSM: next state and bmem request outputs
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wdone_d      = 1'b0;
    dfp_ready    = 1'b0;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_addr    = '0;
    bmem_wdata   = '0;
    rd_accept    = 1'b0;
    wr_accept    = 1'b0;
    req_conflict = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dfp_read && dfp_write) begin
          req_conflict = 1'b1;
        end else begin
          // Writes bypass the outstanding limit; only reads occupy tracker slots.
          dfp_ready = bmem_ready && (dfp_write || (count_q < 4'(MAX_OUTSTANDING)));
        end
        if (dfp_ready && dfp_read) begin
          rd_accept = 1'b1;
          bmem_read = 1'b1;
          bmem_addr = {dfp_addr[31:5], 5'b0};
        end
        if (dfp_ready && dfp_write) begin
          wr_accept  = 1'b1;
          bmem_write = 1'b1;
          bmem_addr  = {dfp_addr[31:5], 5'b0};
          bmem_wdata = dfp_wdata[63:0];
          state_d    = StWrite;
          beat_d     = 2'd1;
        end
      end
      StWrite: begin
        // Remaining beats stream back-to-back; bmem_ready is not consulted.
        bmem_write = 1'b1;
        bmem_addr  = {waddr_q, 5'b0};
        bmem_wdata = wline_q[{beat_q, 6'b0} +: 64];
        beat_d     = beat_q + 2'd1;
        if (beat_q == 2'(BEATS - 1)) begin
          state_d = StIdle;
          beat_d  = 2'd0;
          wdone_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lowest free tracker slot for a new read
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IdxW'(i);
    end
  end

  // Tracker lookup of the returning beat's tag
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (valid_q[i] && ({taddr_q[i], 5'b0} == bmem_raddr)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  // Response collection, independent of the issue FSM
  always_comb begin
    coll_d     = coll_q;
    cur_addr_d = cur_addr_q;
    cur_slot_d = cur_slot_q;
    rbuf_d     = rbuf_q;
    resp_d     = 1'b0;
    rdata_d    = rdata_q;
    raddr_d    = raddr_q;
    err_d      = err_q | req_conflict;
    free       = 1'b0;
    if (bmem_rvalid) begin
      if (coll_q == 2'd0) begin
        if ((count_q == 4'd0) || !hit) begin
          err_d = 1'b1;
        end else begin
          rbuf_d[63:0] = bmem_rdata;
          cur_addr_d   = bmem_raddr;
          cur_slot_d   = hit_idx;
          coll_d       = 2'd1;
        end
      end else if (bmem_raddr != cur_addr_q) begin
        // Tag changed mid-burst: drop the partial line.
        err_d  = 1'b1;
        coll_d = 2'd0;
      end else if (coll_q == 2'(BEATS - 1)) begin
        free    = 1'b1;
        resp_d  = 1'b1;
        rdata_d = {bmem_rdata, rbuf_q};
        raddr_d = cur_addr_q;
        coll_d  = 2'd0;
      end else begin
        rbuf_d[{coll_q, 6'b0} +: 64] = bmem_rdata;
        coll_d = coll_q + 2'd1;
      end
    end
  end

  // Allocation and release never hit the same slot: alloc_idx is free, cur_slot_q is busy.
  always_comb begin
    valid_d = valid_q;
    if (free) valid_d[cur_slot_q] = 1'b0;
    if (rd_accept) valid_d[alloc_idx] = 1'b1;
    count_d = count_q + {3'b0, rd_accept} - {3'b0, free};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      wline_q    <= '0;
      waddr_q    <= '0;
      wdone_q    <= 1'b0;
      valid_q    <= '0;
      taddr_q    <= '0;
      count_q    <= '0;
      coll_q     <= '0;
      cur_addr_q <= '0;
      cur_slot_q <= '0;
      rbuf_q     <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      raddr_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wdone_q    <= wdone_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      coll_q     <= coll_d;
      cur_addr_q <= cur_addr_d;
      cur_slot_q <= cur_slot_d;
      rbuf_q     <= rbuf_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      raddr_q    <= raddr_d;
      err_q      <= err_d;
      if (wr_accept) begin
        wline_q <= dfp_wdata;
        waddr_q <= dfp_addr[31:5];
      end
      if (rd_accept) taddr_q[alloc_idx] <= dfp_addr[31:5];
    end
  end

  assign dfp_resp  = resp_q;
  assign dfp_rdata = rdata_q;
  assign dfp_raddr = raddr_q;
  assign dfp_wdone = wdone_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed testbench for bmem_line_adapter. Inputs change on the falling edge;
// outputs are checked 1 ns later, away from the rising edge.
module tb_bmem_line_adapter;

  logic         clk, rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata;
  logic         dfp_ready, dfp_resp, dfp_wdone;
  logic [31:0]  dfp_raddr;
  logic [255:0] dfp_rdata;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         err;

  int total = 0;
  int bad   = 0;

  logic [255:0] wl;
  logic [255:0] rl;

  bmem_line_adapter #(.MAX_OUTSTANDING(4), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_ready(dfp_ready), .dfp_resp(dfp_resp),
    .dfp_raddr(dfp_raddr), .dfp_rdata(dfp_rdata), .dfp_wdone(dfp_wdone),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] bd(input logic [31:0] a, input int k);
    return {a, 32'(k + 1)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] a, input logic [63:0] d);
    bmem_rvalid = 1'b1;
    bmem_raddr  = a;
    bmem_rdata  = d;
  endtask

  task automatic nobeat();
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bmem_ready = 1'b0; dfp_read = 0; dfp_write = 0;
    dfp_addr = '0; dfp_wdata = '0; nobeat();
    repeat (2) step();
    #1;
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", dfp_ready); end
    total++; if (dfp_resp !== 1'b0) begin bad++; $display("FAIL rst_resp got=%0h exp=0", dfp_resp); end
    total++; if (dfp_wdone !== 1'b0) begin bad++; $display("FAIL rst_wdone got=%0h exp=0", dfp_wdone); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", err); end
    total++; if (dfp_rdata !== 256'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", dfp_rdata); end
    total++; if (dfp_raddr !== 32'h0) begin bad++; $display("FAIL rst_raddr got=%h exp=0", dfp_raddr); end
    total++; if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin
      bad++; $display("FAIL rst_bmem got=%0h%0h exp=00", bmem_read, bmem_write);
    end
    step();
    rst = 1'b0; bmem_ready = 1'b1;
  endtask

  task automatic test_single_read();
    step(); dfp_read = 1; dfp_addr = 32'h0000_1047; #1;
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL sr_ready got=%0h exp=1", dfp_ready); end
    total++; if (bmem_read !== 1'b1) begin bad++; $display("FAIL sr_bmem_read got=%0h exp=1", bmem_read); end
    total++; if (bmem_addr !== 32'h1040) begin bad++; $display("FAIL sr_addr got=%h exp=1040", bmem_addr); end
    step(); dfp_read = 0; #1;
    total++; if (bmem_read !== 1'b0) begin bad++; $display("FAIL sr_pulse got=%0h exp=0", bmem_read); end
    rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    for (int k = 0; k < 4; k++) begin
      step(); beat(32'h1040, rl[k*64 +: 64]); #1;
      total++; if (dfp_resp !== 1'b0) begin bad++; $display("FAIL sr_early_resp k=%0d got=%0h exp=0", k, dfp_resp); end
    end
    step(); nobeat(); #1;
    total++; if (dfp_resp !== 1'b1) begin bad++; $display("FAIL sr_resp got=%0h exp=1", dfp_resp); end
    total++; if (dfp_rdata !== rl) begin bad++; $display("FAIL sr_rdata got=%h exp=%h", dfp_rdata, rl); end
    total++; if (dfp_raddr !== 32'h1040) begin bad++; $display("FAIL sr_raddr got=%h exp=1040", dfp_raddr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sr_err got=%0h exp=0", err); end
    step(); #1;
    total++; if (dfp_resp !== 1'b0) begin bad++; $display("FAIL sr_resp_pulse got=%0h exp=0", dfp_resp); end
    total++; if (dfp_rdata !== rl) begin bad++; $display("FAIL sr_rdata_hold got=%h exp=%h", dfp_rdata, rl); end
  endtask

  task automatic test_write();
    wl = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
          64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    step(); dfp_write = 1; dfp_addr = 32'h0000_2000; dfp_wdata = wl; #1;
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%0h exp=1", dfp_ready); end
    total++; if (bmem_write !== 1'b1) begin bad++; $display("FAIL wr_beat0 got=%0h exp=1", bmem_write); end
    total++; if (bmem_wdata !== 64'hAAAA_0000_0000_000A) begin bad++; $display("FAIL wr_data0 got=%h exp=aaaa00000000000a", bmem_wdata); end
    total++; if (bmem_addr !== 32'h2000) begin bad++; $display("FAIL wr_addr0 got=%h exp=2000", bmem_addr); end
    for (int k = 1; k < 4; k++) begin
      step(); dfp_write = 0; #1;
      total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL wr_busy k=%0d got=%0h exp=0", k, dfp_ready); end
      total++; if (bmem_write !== 1'b1) begin bad++; $display("FAIL wr_valid k=%0d got=%0h exp=1", k, bmem_write); end
      total++; if (bmem_wdata !== wl[k*64 +: 64]) begin bad++; $display("FAIL wr_data k=%0d got=%h exp=%h", k, bmem_wdata, wl[k*64 +: 64]); end
      total++; if (bmem_addr !== 32'h2000) begin bad++; $display("FAIL wr_addr k=%0d got=%h exp=2000", k, bmem_addr); end
      total++; if (dfp_wdone !== 1'b0) begin bad++; $display("FAIL wr_early_done k=%0d got=%0h exp=0", k, dfp_wdone); end
    end
    step(); #1;
    total++; if (dfp_wdone !== 1'b1) begin bad++; $display("FAIL wr_done got=%0h exp=1", dfp_wdone); end
    total++; if (bmem_write !== 1'b0) begin bad++; $display("FAIL wr_end got=%0h exp=0", bmem_write); end
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL wr_idle_ready got=%0h exp=1", dfp_ready); end
    step(); #1;
    total++; if (dfp_wdone !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%0h exp=0", dfp_wdone); end
  endtask

  task automatic test_outstanding();
    for (int i = 1; i <= 4; i++) begin
      step(); dfp_read = 1; dfp_addr = 32'(i * 32'h100); #1;
      total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL mo_accept i=%0d got=%0h exp=1", i, dfp_ready); end
      total++; if (bmem_addr !== 32'(i * 32'h100)) begin bad++; $display("FAIL mo_addr i=%0d got=%h", i, bmem_addr); end
    end
    step(); dfp_addr = 32'h500; #1;
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL mo_full got=%0h exp=0", dfp_ready); end
    total++; if (bmem_read !== 1'b0) begin bad++; $display("FAIL mo_full_read got=%0h exp=0", bmem_read); end
    // A write is still taken at full read count.
    dfp_read = 0; dfp_write = 1; dfp_addr = 32'h3000; dfp_wdata = wl; #1;
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL mo_write_ready got=%0h exp=1", dfp_ready); end
    // 0x300 returns first, overlapping the write beats.
    for (int k = 0; k < 4; k++) begin
      step(); dfp_write = 0; beat(32'h300, bd(32'h300, k));
      if (k == 3) begin dfp_read = 1; dfp_addr = 32'h500; end
      #1;
      total++; if (bmem_write !== (k < 3)) begin bad++; $display("FAIL mo_wbeat k=%0d got=%0h", k, bmem_write); end
    end
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL mo_still_full got=%0h exp=0", dfp_ready); end
    total++; if (dfp_wdone !== 1'b1) begin bad++; $display("FAIL mo_wdone got=%0h exp=1", dfp_wdone); end
    step(); nobeat(); #1;
    rl = {bd(32'h300, 3), bd(32'h300, 2), bd(32'h300, 1), bd(32'h300, 0)};
    total++; if (dfp_resp !== 1'b1) begin bad++; $display("FAIL mo_resp got=%0h exp=1", dfp_resp); end
    total++; if (dfp_raddr !== 32'h300) begin bad++; $display("FAIL mo_raddr got=%h exp=300", dfp_raddr); end
    total++; if (dfp_rdata !== rl) begin bad++; $display("FAIL mo_rdata got=%h exp=%h", dfp_rdata, rl); end
    total++; if (dfp_ready !== 1'b1 || bmem_read !== 1'b1) begin
      bad++; $display("FAIL mo_fifth got=%0h%0h exp=11", dfp_ready, bmem_read);
    end
    total++; if (bmem_addr !== 32'h500) begin bad++; $display("FAIL mo_fifth_addr got=%h exp=500", bmem_addr); end
  endtask

  task automatic test_full_overlap();
    // Outstanding: 100, 200, 400, 500.
    for (int k = 0; k < 4; k++) begin
      step(); beat(32'h100, bd(32'h100, k)); dfp_read = 1; dfp_addr = 32'h600; #1;
      total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL fo_stall k=%0d got=%0h exp=0", k, dfp_ready); end
    end
    step(); nobeat(); #1;
    total++; if (dfp_resp !== 1'b1 || dfp_raddr !== 32'h100) begin
      bad++; $display("FAIL fo_resp got=%0h/%h exp=1/100", dfp_resp, dfp_raddr);
    end
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL fo_reuse got=%0h exp=1", dfp_ready); end
    step(); dfp_addr = 32'h700; #1;
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL fo_refull got=%0h exp=0", dfp_ready); end
    dfp_read = 0;
    for (int k = 0; k < 4; k++) begin
      step(); beat(32'h200, bd(32'h200, k)); #1;
    end
    step(); nobeat(); #1;
    total++; if (dfp_resp !== 1'b1 || dfp_raddr !== 32'h200) begin
      bad++; $display("FAIL fo_resp200 got=%0h/%h exp=1/200", dfp_resp, dfp_raddr);
    end
    // Count is 3: accept 0x700 in the same cycle 0x400 completes.
    for (int k = 0; k < 4; k++) begin
      step(); beat(32'h400, bd(32'h400, k));
      dfp_read = (k == 3); dfp_addr = 32'h700; #1;
    end
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL fo_both got=%0h exp=1", dfp_ready); end
    step(); nobeat(); dfp_read = 1; dfp_addr = 32'h800; #1;
    total++; if (dfp_resp !== 1'b1 || dfp_raddr !== 32'h400) begin
      bad++; $display("FAIL fo_resp400 got=%0h/%h exp=1/400", dfp_resp, dfp_raddr);
    end
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL fo_count3 got=%0h exp=1", dfp_ready); end
    step(); dfp_addr = 32'h900; #1;
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL fo_count4 got=%0h exp=0", dfp_ready); end
    dfp_read = 0;
  endtask

  task automatic test_bad_raddr();
    for (int k = 0; k < 4; k++) begin
      step(); beat(32'h900, bd(32'h900, k)); #1;
      total++; if (err !== (k > 0)) begin bad++; $display("FAIL br_err k=%0d got=%0h", k, err); end
    end
    step(); nobeat(); #1;
    total++; if (dfp_resp !== 1'b0) begin bad++; $display("FAIL br_noresp got=%0h exp=0", dfp_resp); end
    repeat (3) step();
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL br_sticky got=%0h exp=1", err); end
  endtask

  task automatic test_reset_mid_write();
    step(); dfp_write = 1; dfp_addr = 32'h4000; dfp_wdata = wl; #1;
    total++; if (bmem_write !== 1'b1) begin bad++; $display("FAIL rw_beat0 got=%0h exp=1", bmem_write); end
    step(); dfp_write = 0; #1;
    step(); #1;
    total++; if (bmem_wdata !== wl[128 +: 64]) begin bad++; $display("FAIL rw_beat2 got=%h exp=%h", bmem_wdata, wl[128 +: 64]); end
    rst = 1; #1;
    total++; if (bmem_write !== 1'b0) begin bad++; $display("FAIL rw_abandon got=%0h exp=0", bmem_write); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rw_err_clr got=%0h exp=0", err); end
    step(); rst = 0; #1;
    total++; if (dfp_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%0h exp=1", dfp_ready); end
    total++; if (bmem_write !== 1'b0) begin bad++; $display("FAIL rw_idle got=%0h exp=0", bmem_write); end
    bmem_ready = 0; #1;
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL rw_ready_follow got=%0h exp=0", dfp_ready); end
    bmem_ready = 1;
    // 0x500 was outstanding before reset; the tracker must have forgotten it.
    step(); beat(32'h500, bd(32'h500, 0)); #1;
    step(); nobeat(); #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rw_tracker_clr got=%0h exp=1", err); end
  endtask

  task automatic test_conflict();
    step(); rst = 1; #1;
    step(); rst = 0; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL cf_pre_err got=%0h exp=0", err); end
    step(); dfp_read = 1; dfp_write = 1; dfp_addr = 32'h6000; dfp_wdata = wl; #1;
    total++; if (dfp_ready !== 1'b0) begin bad++; $display("FAIL cf_ready got=%0h exp=0", dfp_ready); end
    total++; if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin
      bad++; $display("FAIL cf_issue got=%0h%0h exp=00", bmem_read, bmem_write);
    end
    step(); dfp_read = 0; dfp_write = 0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL cf_err got=%0h exp=1", err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_outstanding();
    test_full_overlap();
    test_bad_raddr();
    test_reset_mid_write();
    test_conflict();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
